// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS instruction-fetch stage feeding the IF/ID register
//
// Owns the program counter and fetches from instruction memory over a
// req/ready handshake. Presents the fetched instruction with its PC and PC+4,
// honours hazard stalls and branch/jump redirects, and inserts bubbles while
// memory is slow.
//
// Ports:
//   clk, Reset          clock; synchronous active-high reset
//   stall               hazard unit: downstream cannot accept, hold outputs
//   redirect_valid/_pc  taken branch/jump and its target (low 2 bits ignored)
//   imem_req/_addr      fetch request and word-aligned address
//   imem_ready/_rdata   memory response for the current request
//   currentPC_out       PC of instr_out
//   nextPC_out          currentPC_out + PC_INC
//   instr_out           fetched instruction, 0 (NOP) on a bubble
//   instr_valid         instr_out is a real instruction
//   fetch_busy          1 while in FLUSH or HOLD
//
// Optional: define IF_PERF_COUNT_EN to add saturating counters
//   perf_fetch_cnt, perf_bubble_cnt, perf_redirect_cnt.

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          PC_INC   = 4
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] currentPC_out,
  output logic [31:0] nextPC_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fetch_busy
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_redirect_cnt
`endif
);

  localparam logic [31:0] PC_STEP = 32'(PC_INC);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] pend_pc, pend_pc_d;
  logic [31:0] hold_instr, hold_instr_d;
  logic [31:0] cur_pc_d, next_pc_d, instr_d;
  logic        valid_d;
  logic [31:0] redirect_tgt;

  // Targets are forced to a word boundary when loaded.
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // In FLUSH pc has not yet moved to the target, so pc is still the address
  // of the outstanding request and stays stable until ready.
  assign imem_req   = !Reset && (state == FETCH || state == FLUSH);
  assign imem_addr  = pc;
  assign fetch_busy = (state == HOLD) || (state == FLUSH);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      pend_pc       <= 32'h0;
      hold_instr    <= 32'h0;
      currentPC_out <= 32'h0;
      nextPC_out    <= 32'h0;
      instr_out     <= 32'h0;
      instr_valid   <= 1'b0;
    end else begin
      state         <= state_d;
      pc            <= pc_d;
      pend_pc       <= pend_pc_d;
      hold_instr    <= hold_instr_d;
      currentPC_out <= cur_pc_d;
      nextPC_out    <= next_pc_d;
      instr_out     <= instr_d;
      instr_valid   <= valid_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    pend_pc_d    = pend_pc;
    hold_instr_d = hold_instr;
    cur_pc_d     = currentPC_out;
    next_pc_d    = nextPC_out;
    instr_d      = instr_out;
    valid_d      = instr_valid;

    case (state)
      FETCH: begin
        if (redirect_valid) begin
          // Flush outputs even under stall: the pending instruction is on the
          // wrong path.
          instr_d = 32'h0;
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = redirect_tgt;
          end else begin
            pend_pc_d = redirect_tgt;
            state_d   = FLUSH;
          end
        end else if (imem_ready && !stall) begin
          instr_d   = imem_rdata;
          cur_pc_d  = pc;
          next_pc_d = pc + PC_STEP;
          valid_d   = 1'b1;
          pc_d      = pc + PC_STEP;
        end else if (imem_ready) begin
          hold_instr_d = imem_rdata;
          state_d      = HOLD;
        end else if (!stall) begin
          instr_d = 32'h0;
          valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          instr_d = 32'h0;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (!stall) begin
          instr_d   = hold_instr;
          cur_pc_d  = pc;
          next_pc_d = pc + PC_STEP;
          valid_d   = 1'b1;
          pc_d      = pc + PC_STEP;
          state_d   = FETCH;
        end
      end

      FLUSH: begin
        instr_d = 32'h0;
        valid_d = 1'b0;
        if (redirect_valid) begin
          pend_pc_d = redirect_tgt;
        end
        if (imem_ready) begin
          // A redirect arriving on the completing cycle is the newest target.
          pc_d    = redirect_valid ? redirect_tgt : pend_pc;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

`ifdef IF_PERF_COUNT_EN
  logic fetch_evt, bubble_evt, redirect_evt;

  // Mirrors the cases above in which instr_valid is reloaded.
  assign fetch_evt = !Reset && !redirect_valid && !stall &&
                     ((state == FETCH && imem_ready) || state == HOLD);
  assign bubble_evt = !Reset && !stall &&
                      ((state == FETCH && (redirect_valid || !imem_ready)) ||
                       (state == HOLD && redirect_valid) ||
                       (state == FLUSH));
  assign redirect_evt = !Reset && redirect_valid;

  always_ff @(posedge clk) begin
    if (Reset) begin
      perf_fetch_cnt    <= 32'h0;
      perf_bubble_cnt   <= 32'h0;
      perf_redirect_cnt <= 32'h0;
    end else begin
      if (fetch_evt && perf_fetch_cnt != 32'hFFFFFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (bubble_evt && perf_bubble_cnt != 32'hFFFFFFFF)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (redirect_evt && perf_redirect_cnt != 32'hFFFFFFFF)
        perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed vector bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] currentPC_out;
  logic [31:0] nextPC_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fetch_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk            (clk),
    .Reset          (Reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .currentPC_out  (currentPC_out),
    .nextPC_out     (nextPC_out),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .fetch_busy     (fetch_busy)
  );

  // Inputs for one cycle; combinational outputs expected before the edge,
  // registered outputs expected after it.
  typedef struct {
    logic        rst;
    logic        stl;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_cur;
    logic [31:0] e_nxt;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stl, input logic rv,
                              input logic [31:0] rpc, input logic rdy,
                              input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic e_busy,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_cur, input logic [31:0] e_nxt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_cur = e_cur; v.e_nxt = e_nxt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    Reset          = v.rst;
    stall          = v.stl;
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    imem_ready     = v.rdy;
    imem_rdata     = v.rdata;
    #1;
    chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, v.e_req});
    if (!v.rst) begin
      chk({tag, ".fetch_busy"}, {31'b0, fetch_busy}, {31'b0, v.e_busy});
      if (v.e_req) chk({tag, ".imem_addr"}, imem_addr, v.e_addr);
    end
    @(posedge clk);
    #1;
    chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, v.e_valid});
    chk({tag, ".instr_out"}, instr_out, v.e_instr);
    chk({tag, ".currentPC_out"}, currentPC_out, v.e_cur);
    chk({tag, ".nextPC_out"}, nextPC_out, v.e_nxt);
  endtask

  vec_t vecs[32];

  initial begin
    Reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_ready = 1'b0; imem_rdata = 32'h0;

    //          rst stl rv rpc          rdy rdata         req addr         bsy vld instr         cur          nxt
    vecs[0]  = mk(1, 0, 0, 32'h0,       0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0,       32'h0);
    // zero-wait memory: 0, 4, 8, C
    vecs[1]  = mk(0, 0, 0, 32'h0,       1, 32'h20010001, 1, 32'h0,        0, 1, 32'h20010001, 32'h0,       32'h4);
    vecs[2]  = mk(0, 0, 0, 32'h0,       1, 32'h20020002, 1, 32'h4,        0, 1, 32'h20020002, 32'h4,       32'h8);
    vecs[3]  = mk(0, 0, 0, 32'h0,       1, 32'h20030003, 1, 32'h8,        0, 1, 32'h20030003, 32'h8,       32'hC);
    vecs[4]  = mk(0, 0, 0, 32'h0,       1, 32'h20040004, 1, 32'hC,        0, 1, 32'h20040004, 32'hC,       32'h10);
    // two wait states at 0x10
    vecs[5]  = mk(0, 0, 0, 32'h0,       0, 32'h0,        1, 32'h10,       0, 0, 32'h0,        32'hC,       32'h10);
    vecs[6]  = mk(0, 0, 0, 32'h0,       0, 32'h0,        1, 32'h10,       0, 0, 32'h0,        32'hC,       32'h10);
    vecs[7]  = mk(0, 0, 0, 32'h0,       1, 32'h20050005, 1, 32'h10,       0, 1, 32'h20050005, 32'h10,      32'h14);
    vecs[8]  = mk(0, 0, 0, 32'h0,       1, 32'h20060006, 1, 32'h14,       0, 1, 32'h20060006, 32'h14,      32'h18);
    vecs[9]  = mk(0, 0, 0, 32'h0,       1, 32'h20070007, 1, 32'h18,       0, 1, 32'h20070007, 32'h18,      32'h1C);
    vecs[10] = mk(0, 0, 0, 32'h0,       1, 32'h20080008, 1, 32'h1C,       0, 1, 32'h20080008, 32'h1C,      32'h20);
    // stall on the ready cycle at 0x20 -> HOLD
    vecs[11] = mk(0, 1, 0, 32'h0,       1, 32'h8C220004, 1, 32'h20,       0, 1, 32'h20080008, 32'h1C,      32'h20);
    vecs[12] = mk(0, 1, 0, 32'h0,       0, 32'h0,        0, 32'h0,        1, 1, 32'h20080008, 32'h1C,      32'h20);
    vecs[13] = mk(0, 0, 0, 32'h0,       0, 32'h0,        0, 32'h0,        1, 1, 32'h8C220004, 32'h20,      32'h24);
    vecs[14] = mk(0, 0, 0, 32'h0,       1, 32'h20090009, 1, 32'h24,       0, 1, 32'h20090009, 32'h24,      32'h28);
    vecs[15] = mk(0, 0, 0, 32'h0,       1, 32'h200A000A, 1, 32'h28,       0, 1, 32'h200A000A, 32'h28,      32'h2C);
    vecs[16] = mk(0, 0, 0, 32'h0,       1, 32'h200B000B, 1, 32'h2C,       0, 1, 32'h200B000B, 32'h2C,      32'h30);
    // redirect to 0x100 while 0x30 outstanding -> FLUSH, 0x30 data dropped
    vecs[17] = mk(0, 0, 1, 32'h100,     0, 32'h0,        1, 32'h30,       0, 0, 32'h0,        32'h2C,      32'h30);
    vecs[18] = mk(0, 0, 0, 32'h0,       0, 32'h0,        1, 32'h30,       1, 0, 32'h0,        32'h2C,      32'h30);
    vecs[19] = mk(0, 0, 0, 32'h0,       1, 32'hDEAD0030, 1, 32'h30,       1, 0, 32'h0,        32'h2C,      32'h30);
    vecs[20] = mk(0, 0, 0, 32'h0,       1, 32'h200C000C, 1, 32'h100,      0, 1, 32'h200C000C, 32'h100,     32'h104);
    // misaligned redirect with ready in FETCH
    vecs[21] = mk(0, 0, 1, 32'h103,     1, 32'hBAD00104, 1, 32'h104,      0, 0, 32'h0,        32'h100,     32'h104);
    vecs[22] = mk(0, 0, 0, 32'h0,       1, 32'h200D000D, 1, 32'h100,      0, 1, 32'h200D000D, 32'h100,     32'h104);
    // two redirects during FLUSH: latest wins
    vecs[23] = mk(0, 0, 1, 32'h200,     0, 32'h0,        1, 32'h104,      0, 0, 32'h0,        32'h100,     32'h104);
    vecs[24] = mk(0, 0, 1, 32'h300,     0, 32'h0,        1, 32'h104,      1, 0, 32'h0,        32'h100,     32'h104);
    vecs[25] = mk(0, 0, 0, 32'h0,       1, 32'hBAD00104, 1, 32'h104,      1, 0, 32'h0,        32'h100,     32'h104);
    vecs[26] = mk(0, 0, 0, 32'h0,       1, 32'h200E000E, 1, 32'h300,      0, 1, 32'h200E000E, 32'h300,     32'h304);
    // redirect while in HOLD drops the held word
    vecs[27] = mk(0, 1, 0, 32'h0,       1, 32'hBAD00304, 1, 32'h304,      0, 1, 32'h200E000E, 32'h300,     32'h304);
    vecs[28] = mk(0, 1, 1, 32'h40,      0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h300,     32'h304);
    vecs[29] = mk(0, 0, 0, 32'h0,       1, 32'h200F000F, 1, 32'h40,       0, 1, 32'h200F000F, 32'h40,      32'h44);
    // stall with no data: everything held
    vecs[30] = mk(0, 1, 0, 32'h0,       0, 32'h0,        1, 32'h44,       0, 1, 32'h200F000F, 32'h40,      32'h44);
    vecs[31] = mk(0, 0, 0, 32'h0,       1, 32'h20100010, 1, 32'h44,       0, 1, 32'h20100010, 32'h44,      32'h48);

    for (int i = 0; i < 32; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // PC wrap: redirect to 0xFFFFFFFF (aligned to ...FC), then advance past 2^32
    apply("wrap0", mk(0, 0, 1, 32'hFFFFFFFF, 1, 32'hBAD00048, 1, 32'h48,       0, 0, 32'h0,        32'h44,       32'h48));
    apply("wrap1", mk(0, 0, 0, 32'h0,        1, 32'h20110011, 1, 32'hFFFFFFFC, 0, 1, 32'h20110011, 32'hFFFFFFFC, 32'h0));
    apply("wrap2", mk(0, 0, 0, 32'h0,        1, 32'h20120012, 1, 32'h0,        0, 1, 32'h20120012, 32'h0,        32'h4));

    // Reset asserted while in HOLD
    apply("rst0", mk(0, 1, 0, 32'h0, 1, 32'hBAD00004, 1, 32'h4, 0, 1, 32'h20120012, 32'h0, 32'h4));
    apply("rst1", mk(1, 1, 0, 32'h0, 0, 32'h0,        0, 32'h0, 0, 0, 32'h0,        32'h0, 32'h0));
    apply("rst2", mk(0, 0, 0, 32'h0, 0, 32'h0,        1, 32'h0, 0, 0, 32'h0,        32'h0, 32'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter and issues requests to instruction memory over a req/ready handshake. It presents the fetched instruction with its current PC and PC+4 to the IF/ID register. It honours hazard-unit stalls and branch/jump redirects, and inserts bubbles when memory is slow.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
PC_INC, 4, byte increment between sequential instructions.

Ports:
clk  input  1  clock, all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
stall  input  1  from hazard unit; 1 = downstream cannot accept, hold outputs.
redirect_valid  input  1  branch/jump taken, resolved downstream.
redirect_pc  input  32  target PC for redirect.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; word-aligned.
imem_ready  input  1  memory has returned data for the current request.
imem_rdata  input  32  instruction word, valid when imem_ready=1.
currentPC_out  output  32  PC of instr_out.
nextPC_out  output  32  currentPC_out + PC_INC.
instr_out  output  32  fetched instruction; 32'h00000000 (NOP) when bubble.
instr_valid  output  1  instr_out is a real instruction.
fetch_busy  output  1  1 while in FLUSH or HOLD.

Behaviour:
- Registers: pc, pend_pc (redirect target held during FLUSH), hold_instr, state in {FETCH, HOLD, FLUSH}.
- Reset (synchronous, active-high) has priority over everything:
  - pc=RESET_PC; state=FETCH.
  - currentPC_out, nextPC_out, instr_out = 0; instr_valid=0.
  - imem_req forced 0 while Reset=1.
- Combinational outputs: imem_req = !Reset && (state==FETCH || state==FLUSH). imem_addr = pc in FETCH, old pc in FLUSH. Address stays stable until ready.
- FETCH:
  - redirect_valid && imem_ready: discard rdata. pc=redirect_pc. instr_valid=0, instr_out=0 (outputs are flushed regardless of stall). Stay in FETCH.
  - redirect_valid && !imem_ready: pend_pc=redirect_pc. instr_valid=0, instr_out=0. Go to FLUSH.
  - imem_ready && !stall: instr_out=rdata, currentPC_out=pc, nextPC_out=pc+PC_INC, instr_valid=1, pc=pc+PC_INC.
  - imem_ready && stall: hold_instr=rdata. Outputs unchanged. Go to HOLD.
  - !imem_ready && !stall: bubble (instr_valid=0, instr_out=0; PC outputs unchanged).
  - !imem_ready && stall: all outputs unchanged.
- HOLD (imem_req=0):
  - redirect_valid: pc=redirect_pc. hold_instr dropped. instr_valid=0, instr_out=0. Go to FETCH.
  - !stall: outputs = hold_instr / pc / pc+PC_INC; instr_valid=1. pc=pc+PC_INC. Go to FETCH.
  - stall: stay in HOLD.
- FLUSH (request still outstanding):
  - imem_ready: discard data. pc=pend_pc. Go to FETCH.
  - A further redirect_valid overwrites pend_pc; the latest redirect wins.
  - Outputs stay bubble (instr_valid=0).
- PC arithmetic is modulo 2^32; 32'hFFFFFFFC + 4 wraps to 0. The low 2 bits of redirect_pc are cleared on load.
- Latency: instruction visible one cycle after the imem_ready edge. With zero-wait memory, throughput is 1 instr/cycle.
- Reset asserted mid-request: the request is abandoned. Memory must tolerate imem_req dropping.

Optional Feature:
IF_PERF_COUNT_EN: when defined, adds these outputs, reset to 0:
- perf_fetch_cnt [31:0]: counts cycles where instr_valid is loaded with 1.
- perf_bubble_cnt [31:0]: counts cycles where instr_valid is loaded with 0 and stall=0.
- perf_redirect_cnt [31:0]: counts redirect_valid cycles.
Counters saturate at 32'hFFFFFFFF. When the macro is undefined, these ports and their logic do not exist.

Test Plan:
- Reset, then zero-wait memory for 3 cycles: imem_addr sequence 0, 4, 8. Outputs (currentPC, nextPC, instr_valid) = (0,4,1), then (4,8,1), then (8,12,1).
- imem_ready low for 2 cycles at pc=0x10, stall=0: instr_valid=0 and instr_out=0 for 2 cycles, then instr at currentPC_out=0x10.
- stall=1 on the ready cycle at pc=0x20 (rdata=0x8C220004): outputs held, fetch_busy=1, imem_req=0. After stall drops: instr_out=0x8C220004, currentPC_out=0x20, next imem_addr=0x24.
- redirect_valid with redirect_pc=0x100 while a request is outstanding at 0x30: enter FLUSH; 0x30 data is discarded on ready; next imem_addr=0x100; no valid instruction from 0x30 appears.
- redirect_pc=0x103 in FETCH with imem_ready=1: pc loads 0x100. PC at 0xFFFFFFFC advances to 0x00000000.
- Reset asserted during HOLD: all outputs 0, state FETCH, imem_addr=RESET_PC on the following cycle.
